// File: rtl/jelly3_img_bayer_pattern_gen.sv
// Bayer test-pattern source producing framed raw pixels with programmable size, blanking and level per phase.
// Latency: first pixel one edge after the latching edge; no backpressure, everything freezes while cke=0.
module jelly3_img_bayer_pattern_gen #(
    parameter int DATA_BITS   = 10,
    parameter int WIDTH_BITS  = 12,
    parameter int HEIGHT_BITS = 12,
    parameter int FRAME_BITS  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cke,
    input  logic                       enable,
    input  logic [WIDTH_BITS-1:0]      param_width,
    input  logic [HEIGHT_BITS-1:0]     param_height,
    input  logic [WIDTH_BITS-1:0]      param_h_blank,
    input  logic [HEIGHT_BITS-1:0]     param_v_blank,
    input  logic [1:0]                 param_phase,
    input  logic [1:0]                 param_mode,
    input  logic [4*DATA_BITS-1:0]     param_level,
    output logic                       busy,
    output logic [FRAME_BITS-1:0]      frame_count,
    output logic                       m_row_first,
    output logic                       m_row_last,
    output logic                       m_col_first,
    output logic                       m_col_last,
    output logic                       m_de,
    output logic [DATA_BITS-1:0]       m_data,
    output logic                       m_valid
);

    localparam int CNT_BITS = (WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS;

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    typedef struct packed {
        logic [WIDTH_BITS-1:0]         width;
        logic [HEIGHT_BITS-1:0]        height;
        logic [WIDTH_BITS-1:0]         h_blank;
        logic [HEIGHT_BITS-1:0]        v_blank;
        logic [1:0]                    phase;
        logic [1:0]                    mode;
        logic [3:0][DATA_BITS-1:0]     level;
    } param_t;

    state_t                  state_q, state_d;
    param_t                  par_q, par_d, par_in;
    logic [WIDTH_BITS-1:0]   x_q, x_d;
    logic [HEIGHT_BITS-1:0]  y_q, y_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   frame_count_q, frame_count_d;
    logic                    busy_q, busy_d;

    logic                    valid_q, valid_d;
    logic                    row_first_q, row_first_d;
    logic                    row_last_q, row_last_d;
    logic                    col_first_q, col_first_d;
    logic                    col_last_q, col_last_d;
    logic [DATA_BITS-1:0]    data_q, data_d;

    logic                    start_ok;
    logic                    x_last, y_last, h_end, v_end, frame_end;
    logic [1:0]              phase;
    logic [DATA_BITS-1:0]    level, pix;

    always_comb begin
        par_in.width   = param_width;
        par_in.height  = param_height;
        par_in.h_blank = param_h_blank;
        par_in.v_blank = param_v_blank;
        par_in.phase   = param_phase;
        par_in.mode    = param_mode;
        par_in.level   = param_level;
    end

    assign start_ok = enable && (param_width != '0) && (param_height != '0);
    assign x_last   = (x_q == par_q.width - WIDTH_BITS'(1));
    assign y_last   = (y_q == par_q.height - HEIGHT_BITS'(1));
    assign h_end    = (cnt_q == CNT_BITS'(par_q.h_blank - WIDTH_BITS'(1)));
    assign v_end    = (cnt_q == CNT_BITS'(par_q.v_blank - HEIGHT_BITS'(1)));

    // State and position describe the pixel being generated now; the m_* registers show it one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            par_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            frame_count_q <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            row_first_q   <= 1'b0;
            row_last_q    <= 1'b0;
            col_first_q   <= 1'b0;
            col_last_q    <= 1'b0;
            data_q        <= '0;
        end else if (cke) begin
            state_q       <= state_d;
            par_q         <= par_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            row_first_q   <= row_first_d;
            row_last_q    <= row_last_d;
            col_first_q   <= col_first_d;
            col_last_q    <= col_last_d;
            data_q        <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        par_d         = par_q;
        x_d           = x_q;
        y_d           = y_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        frame_end     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = ACTIVE;
                    par_d   = par_in;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ACTIVE: begin
                if (x_last) begin
                    x_d = '0;
                    if (!y_last) begin
                        if (par_q.h_blank != '0) begin
                            state_d = HBLANK;
                            cnt_d   = '0;
                        end else begin
                            y_d = y_q + HEIGHT_BITS'(1);
                        end
                    end else if (par_q.v_blank != '0) begin
                        state_d = VBLANK;
                        cnt_d   = '0;
                    end else begin
                        frame_end = 1'b1;
                    end
                end else begin
                    x_d = x_q + WIDTH_BITS'(1);
                end
            end
            HBLANK: begin
                if (h_end) begin
                    state_d = ACTIVE;
                    y_d     = y_q + HEIGHT_BITS'(1);
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            VBLANK: begin
                if (v_end) begin
                    frame_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            frame_count_d = frame_count_q + FRAME_BITS'(1);
            if (start_ok) begin
                state_d = ACTIVE;
                par_d   = par_in;
                x_d     = '0;
                y_d     = '0;
            end else begin
                state_d = IDLE;
            end
        end

        // Busy covers the visible frame; it drops with the edge that leaves VBLANK for IDLE.
        busy_d = (state_q == ACTIVE) || (state_q == HBLANK) ||
                 ((state_q == VBLANK) && (state_d != IDLE));
    end

    always_comb begin
        phase = par_q.phase ^ {y_q[0], x_q[0]};
        level = par_q.level[phase];
        case (par_q.mode)
            2'd0:    pix = level;
            2'd1:    pix = level + DATA_BITS'(x_q);
            2'd2:    pix = level + DATA_BITS'(y_q);
            default: pix = DATA_BITS'(x_q) ^ DATA_BITS'(y_q);
        endcase

        valid_d     = (state_q == ACTIVE);
        row_first_d = valid_d && (y_q == '0);
        row_last_d  = valid_d && y_last;
        col_first_d = valid_d && (x_q == '0);
        col_last_d  = valid_d && x_last;
        data_d      = valid_d ? pix : '0;
    end

    assign busy        = busy_q;
    assign frame_count = frame_count_q;
    assign m_row_first = row_first_q;
    assign m_row_last  = row_last_q;
    assign m_col_first = col_first_q;
    assign m_col_last  = col_last_q;
    assign m_de        = valid_q;
    assign m_valid     = valid_q;
    assign m_data      = data_q;

endmodule

// File: doc/jelly3_img_bayer_pattern_gen.md
Name: jelly3_img_bayer_pattern_gen

Overview:
- Bayer test-pattern source that drives a raw image stream master: row_first/row_last/col_first/col_last/de/data/valid framing.
- Generates frames of programmable size with blanking. The 2x2 phase sequence matches the Bayer phase convention of the white-balance and black-level stages, so those stages can be driven and checked without a sensor.
- Sits at the head of the image pipeline in place of the sensor receiver.

Parameters:
- DATA_BITS, 10, pixel data width
- WIDTH_BITS, 12, width of the image width and h-blank fields
- HEIGHT_BITS, 12, width of the image height and v-blank fields
- FRAME_BITS, 16, width of the frame counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cke  in  1  clock enable; when 0, all state and outputs hold
- enable  in  1  run request, sampled at frame boundaries
- param_width  in  WIDTH_BITS  pixels per row
- param_height  in  HEIGHT_BITS  rows per frame
- param_h_blank  in  WIDTH_BITS  idle cycles after each non-last row
- param_v_blank  in  HEIGHT_BITS  idle cycles after a frame
- param_phase  in  2  Bayer phase of pixel (0,0)
- param_mode  in  2  0 flat, 1 h-ramp, 2 v-ramp, 3 xor
- param_level  in  4xDATA_BITS  per-phase level
- busy  out  1  frame in progress
- frame_count  out  FRAME_BITS  completed frames
- m_row_first, m_row_last, m_col_first, m_col_last  out  1 each  framing flags
- m_de  out  1  data enable
- m_data  out  DATA_BITS  pixel
- m_valid  out  1  pixel valid

Behaviour:
- Reset: reset_n=0 asynchronously clears everything.
  - All outputs, frame_count and busy go to 0; state goes to IDLE.
  - Applies at any time, including mid-row. No partial frame resumes after reset.
- cke=0: no state or output changes. All descriptions below count cke=1 edges only.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - Outputs are 0.
  - On an edge where enable=1, param_width!=0 and param_height!=0: latch all param_* and go to ACTIVE.
  - If width or height is 0, remain in IDLE with busy=0.
- Latency: pixel (0,0) is on m_* starting at the edge after the latching edge. busy=1 from that same edge.
- ACTIVE: one pixel per cycle, x = 0..width-1, y = current row.
  - m_valid = m_de = 1.
  - col_first = (x==0), col_last = (x==width-1).
  - row_first = (y==0), row_last = (y==height-1).
- After x == width-1:
  - If not the last row and h_blank > 0: go to HBLANK for h_blank cycles, then next row.
  - If not the last row and h_blank == 0: next row with no gap.
  - If the last row: go to VBLANK. No h_blank is inserted after the last row.
- HBLANK / VBLANK: m_valid = m_de = 0; flags and data are driven 0.
- VBLANK:
  - On the edge that ends VBLANK (or at the last pixel when v_blank==0), frame_count increments, wrapping modulo 2^FRAME_BITS.
  - If enable=1 on that edge: relatch params and start the next frame back-to-back.
  - Otherwise go to IDLE and busy drops to 0 on the same edge.
- enable is ignored mid-frame; deasserting it always finishes the current frame.
- Params are used only as latched. Changing a param_* mid-frame has no effect until the next frame.
- Phase: phase = param_phase ^ {y[0], x[0]}.
  - Bit 0 toggles per column; bit 1 toggles per row.
  - Phase indexes param_level.
- Data by mode, truncated to DATA_BITS (modulo 2^DATA_BITS):
  - mode 0: level[phase]
  - mode 1: level[phase] + x
  - mode 2: level[phase] + y
  - mode 3: x ^ y
- 1x1 frame: the single pixel has all four flags = 1.

Test Plan:
- Flat pattern, phase 0:
  - Stimulus: width=4, height=2, h_blank=2, v_blank=3, mode 0, phase 0, levels {10,20,30,40}, enable held.
  - Required: row0 = 10,20,10,20; then 2 invalid cycles; row1 = 30,40,30,40; then 3 invalid cycles; next frame back-to-back.
  - Flags correct on every pixel; frame_count 0→1 at the end of VBLANK.
- Phase 3, same setup: row0 = 40,30,40,30; row1 = 20,10,20,10.
- Horizontal ramp wrap:
  - Stimulus: mode 1, width=8, DATA_BITS=10, all levels=1020.
  - Required: row0 = 1020,1021,1022,1023,0,1,2,3.
- cke handling:
  - Stimulus: toggle cke 1/0 pseudo-randomly through a frame.
  - Required: the valid-pixel sequence is identical to the cke=1 run; outputs hold while cke=0.
- enable dropped mid-frame:
  - Stimulus: deassert enable during row0.
  - Required: the frame completes including v_blank; busy=0 from the next edge; frame_count increments exactly once; width=0 then never starts.
- Asynchronous reset:
  - Stimulus: pull reset_n low mid-row (between clock edges).
  - Required: m_valid=0 and busy=0 immediately; after release with enable=1, the next frame starts at pixel (0,0) with frame_count=0.
